// File: rtl/ifm_tile_streamer.sv
// Double-buffered 5x5 IFM tile store with a 9-step snake-scan window sequencer
// feeding the 3x3 PE array shift buffer.
module ifm_tile_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [4:0]                      wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            wr_commit,
    output logic                            wr_ready,
    input  logic                            start,
    input  logic                            hold,
    output logic [NUM_WORDS*WORD_WIDTH-1:0] ifm_word,
    output logic [2:0]                      ifm_step,
    output logic                            ifm_valid,
    output logic                            busy,
    output logic                            done
);
    localparam int TILE = 25;
    localparam logic [2:0] STEP_ALL = 3'b111;
    localparam logic [2:0] STEP_R   = 3'b001;
    localparam logic [2:0] STEP_D   = 3'b010;
    localparam logic [2:0] STEP_L   = 3'b100;
    localparam logic [2:0] STEP_NC  = 3'b101;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                         state;
    logic [3:0]                     nk;          // next step index to emit; 9 = scan finished
    logic                           wr_bank, rd_bank;
    logic [1:0]                     full, full_next;
    logic [DATA_WIDTH-1:0]          mem [2][TILE];
    logic [DATA_WIDTH-1:0]          tile [TILE];
    logic [3:0]                     ek;
    int                             r0, c0;
    logic [NUM_WORDS*WORD_WIDTH-1:0] nw;
    logic                           commit_ok;

    function automatic logic [4:0] idx(input int r, input int c);
        return 5'(r * 5 + c);
    endfunction

    function automatic logic [2:0] step_code(input logic [3:0] k);
        case (k)
            4'd0:                    return STEP_ALL;
            4'd1, 4'd2, 4'd7, 4'd8:  return STEP_R;
            4'd3, 4'd6:              return STEP_D;
            4'd4, 4'd5:              return STEP_L;
            default:                 return STEP_NC;
        endcase
    endfunction

    assign wr_ready  = !full[wr_bank];
    assign commit_ok = wr_commit && wr_ready;

    always_ff @(posedge clk) begin
        if (wr_en && wr_ready && wr_addr <= 5'd24)
            mem[wr_bank][wr_addr] <= wr_data;
    end

    always_comb begin
        for (int i = 0; i < TILE; i++) tile[i] = mem[rd_bank][i];
    end

    // The word set for the step about to be emitted: step 0 on start, else nk.
    always_comb begin
        ek = (state == RUN) ? nk : 4'd0;
        r0 = int'(ek) / 3;
        c0 = (r0 % 2 == 1) ? 2 - int'(ek) % 3 : int'(ek) % 3;
        nw = '0;
        case (step_code(ek))
            STEP_ALL: begin
                for (int i = 0; i < 3; i++)
                    nw[i*WORD_WIDTH +: 3*DATA_WIDTH] = {tile[idx(r0+i, c0)],
                                                        tile[idx(r0+i, c0+1)],
                                                        tile[idx(r0+i, c0+2)]};
            end
            STEP_R: nw[0 +: 3*DATA_WIDTH] = {tile[idx(r0, c0+2)], tile[idx(r0+1, c0+2)],
                                             tile[idx(r0+2, c0+2)]};
            STEP_D: nw[WORD_WIDTH +: 3*DATA_WIDTH] = {tile[idx(r0+2, c0)], tile[idx(r0+2, c0+1)],
                                                      tile[idx(r0+2, c0+2)]};
            STEP_L: nw[2*WORD_WIDTH +: 3*DATA_WIDTH] = {tile[idx(r0, c0)], tile[idx(r0+1, c0)],
                                                        tile[idx(r0+2, c0)]};
            default: nw = '0;
        endcase
    end

    // Commit and release always target different banks, so both may land together.
    always_comb begin
        full_next = full;
        if (commit_ok) full_next[wr_bank] = 1'b1;
        if (state == DONE) full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            nk        <= 4'd0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            ifm_word  <= '0;
            ifm_step  <= STEP_NC;
            ifm_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            full      <= full_next;
            if (commit_ok) wr_bank <= ~wr_bank;
            ifm_valid <= 1'b0;
            ifm_step  <= STEP_NC;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && full[rd_bank]) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        ifm_word  <= nw;
                        ifm_step  <= STEP_ALL;
                        ifm_valid <= 1'b1;
                        nk        <= 4'd1;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        if (nk == 4'd9) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            ifm_word  <= nw;
                            ifm_step  <= step_code(nk);
                            ifm_valid <= 1'b1;
                            nk        <= nk + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    rd_bank <= ~rd_bank;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifm_tile_streamer.sv
// Randomized bench for ifm_tile_streamer: a tile-FIFO reference model checked every
// cycle, plus directed scenarios pinned with hand-computed literals.
module tb_ifm_tile_streamer;
    localparam int DW = 8;
    localparam int WW = 32;
    localparam int NW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, wr_commit, start, hold;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready, ifm_valid, busy, done;
    logic [NW*WW-1:0] ifm_word;
    logic [2:0]    ifm_step;

    ifm_tile_streamer #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_ready(wr_ready), .start(start), .hold(hold),
        .ifm_word(ifm_word), .ifm_step(ifm_step), .ifm_valid(ifm_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: committed tiles form a FIFO of depth 2 ----------
    typedef logic [199:0] tile_t;
    tile_t       q[$];
    tile_t       pend;
    logic [24:0] mask;
    int          mode, emitted;
    logic [95:0] e_word;
    logic [2:0]  e_step;
    logic        e_valid, e_busy, e_done, m_rdy;

    function automatic logic [7:0] el(input tile_t t, input int r, input int c);
        return t[(r*5+c)*8 +: 8];
    endfunction

    function automatic logic [2:0] step_tab(input int k);
        logic [2:0] s [9] = '{3'b111, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001, 3'b001};
        return s[k];
    endfunction

    function automatic logic [95:0] exp_words(input tile_t t, input int k);
        int ro [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        int co [9] = '{0, 1, 2, 2, 1, 0, 0, 1, 2};
        logic [95:0] w;
        int r, c;
        w = '0;
        r = ro[k];
        c = co[k];
        case (step_tab(k))
            3'b111: for (int i = 0; i < 3; i++)
                        w[i*32 +: 24] = {el(t, r+i, c), el(t, r+i, c+1), el(t, r+i, c+2)};
            3'b001: w[23:0]  = {el(t, r, c+2), el(t, r+1, c+2), el(t, r+2, c+2)};
            3'b010: w[55:32] = {el(t, r+2, c), el(t, r+2, c+1), el(t, r+2, c+2)};
            default: w[87:64] = {el(t, r, c), el(t, r+1, c), el(t, r+2, c)};
        endcase
        return w;
    endfunction

    task automatic reset_model();
        q.delete();
        mode = 0; emitted = 0; mask = '0;
        e_word = '0; e_step = 3'b101; e_valid = 0; e_busy = 0; e_done = 0;
    endtask

    task automatic emit(input int k);
        e_word  = exp_words(q[0], k);
        e_step  = step_tab(k);
        e_valid = 1;
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) reset_model();
            else begin
                m_rdy = (q.size() < 2);
                if (wr_en && m_rdy && wr_addr <= 5'd24) begin
                    pend[int'(wr_addr)*8 +: 8] = wr_data;
                    mask[wr_addr] = 1'b1;
                end
                e_valid = 0; e_step = 3'b101; e_done = 0;
                case (mode)
                    0: if (start && q.size() > 0) begin
                           mode = 1; e_busy = 1; emit(0); emitted = 1;
                       end
                    1: if (!hold) begin
                           if (emitted == 9) begin mode = 2; e_done = 1; end
                           else begin emit(emitted); emitted++; end
                       end
                    default: begin mode = 0; e_busy = 0; void'(q.pop_front()); end
                endcase
                if (wr_commit && m_rdy) begin q.push_back(pend); mask = '0; end
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("valid", ifm_valid, e_valid);
                chk("step", ifm_step, e_step);
                chk("word", ifm_word, e_word);
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("wr_ready", wr_ready, q.size() < 2);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_tile(input tile_t t);
        for (int a = 0; a < 25; a++) begin
            wr_en = 1; wr_addr = 5'(a); wr_data = t[a*8 +: 8];
            tick();
        end
        wr_en = 0;
    endtask

    task automatic commit();
        wr_commit = 1; tick(); wr_commit = 0;
    endtask

    task automatic wait_done(input int from, input int limit, output int n);
        n = from;
        while (done !== 1'b1 && n < limit) begin tick(); n++; end
    endtask

    function automatic tile_t rand_tile();
        tile_t t;
        for (int a = 0; a < 25; a++) t[a*8 +: 8] = 8'($urandom);
        return t;
    endfunction

    tile_t       ta, tb, tc;
    logic [95:0] lit [9];
    logic [2:0]  lit_step [9];
    int          n;

    initial begin
        lit[0] = {32'h00202122, 32'h00101112, 32'h00000102};
        lit[1] = {64'h0, 32'h00031323};
        lit[2] = {64'h0, 32'h00041424};
        lit[3] = {32'h0, 32'h00323334, 32'h0};
        lit[4] = {32'h00112131, 64'h0};
        lit[5] = {32'h00102030, 64'h0};
        lit[6] = {32'h0, 32'h00404142, 32'h0};
        lit[7] = {64'h0, 32'h00233343};
        lit[8] = {64'h0, 32'h00243444};
        lit_step = '{3'b111, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001, 3'b001};
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) ta[(r*5+c)*8 +: 8] = 8'(r*16 + c);

        rst_n = 0; wr_en = 0; wr_commit = 0; start = 0; hold = 0; wr_addr = '0; wr_data = '0;
        repeat (3) tick();
        chk("rst_word", ifm_word, 96'h0);
        chk("rst_step", ifm_step, 3'b101);
        chk("rst_valid", ifm_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        rst_n = 1;
        tick();

        // basic stream
        load_tile(ta); commit();
        start = 1; tick(); start = 0;
        for (int k = 0; k < 9; k++) begin
            chk("basic_step", ifm_step, lit_step[k]);
            chk("basic_word", ifm_word, lit[k]);
            tick();
        end
        chk("basic_done_t10", done, 1'b1);
        tick();
        chk("basic_ready_t11", wr_ready, 1'b1);

        // ping-pong with both banks full, plus ignored write/commit while full
        tb = rand_tile(); tc = rand_tile();
        load_tile(tb); commit();
        load_tile(tc); commit();
        chk("both_full_ready", wr_ready, 1'b0);
        wr_en = 1; wr_addr = 5'd7; wr_data = 8'hEE; wr_commit = 1; tick();
        wr_en = 0; wr_commit = 0;
        start = 1; tick(); start = 0;
        wait_done(1, 30, n);
        chk("pp_done_cycle", n, 10);
        tick();
        chk("pp_ready_t11", wr_ready, 1'b1);
        start = 1; tick(); start = 0;
        chk("pp_restart_valid", ifm_valid, 1'b1);
        chk("pp_restart_step", ifm_step, 3'b111);
        wait_done(1, 30, n);
        chk("pp2_done_cycle", n, 10);
        tick();

        // hold for two cycles ahead of step 4
        load_tile(ta); commit();
        start = 1; tick(); start = 0;
        tick(); tick(); tick();
        hold = 1;
        chk("hold_pre_word", ifm_word, lit[3]);
        tick();
        chk("hold_valid", ifm_valid, 1'b0);
        chk("hold_step", ifm_step, 3'b101);
        chk("hold_word", ifm_word, lit[3]);
        tick();
        hold = 0;
        chk("hold2_valid", ifm_valid, 1'b0);
        chk("hold2_word", ifm_word, lit[3]);
        tick();
        chk("hold_reemit_step", ifm_step, 3'b100);
        chk("hold_reemit_word", ifm_word, lit[4]);
        wait_done(7, 40, n);
        chk("hold_done_cycle", n, 12);
        tick();

        // illegal start and out-of-range write
        start = 1; tick(); start = 0;
        wr_en = 1; wr_addr = 5'd25; wr_data = 8'hFF; tick(); wr_en = 0;
        chk("bad_start_busy", busy, 1'b0);
        chk("bad_start_valid", ifm_valid, 1'b0);

        // reset mid-run at step 5
        load_tile(ta); commit();
        start = 1; tick(); start = 0;
        repeat (5) tick();
        chk("mid_step5", ifm_step, 3'b100);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_word", ifm_word, 96'h0);
        chk("mid_rst_step", ifm_step, 3'b101);
        chk("mid_rst_valid", ifm_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", wr_ready, 1'b1);
        tick();
        rst_n = 1;
        start = 1; tick(); start = 0; tick();
        chk("post_rst_start_busy", busy, 1'b0);

        // randomized traffic; commits only once the pending tile is fully written
        repeat (3000) begin
            wr_en     = ($urandom % 2) == 0;
            wr_addr   = 5'($urandom_range(0, 31));
            wr_data   = 8'($urandom);
            wr_commit = (mask == 25'h1FFFFFF) && ($urandom % 4 == 0);
            start     = ($urandom % 3) == 0;
            hold      = ($urandom % 4) == 0;
            tick();
        end
        wr_en = 0; wr_commit = 0; start = 0; hold = 0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
